// File: rtl/reset_release_sequencer.sv
// ---------------------------------------------------------------------------
// reset_release_sequencer
//
// Releases NUM_STAGES downstream reset domains one at a time, in index order.
// Stage k+1 leaves reset only once stage k has reported ready. The sequence
// starts when the PLL lock is qualified. It aborts and restarts on lock loss,
// on a software request, or when a running stage drops its ready. A stage
// that never reports ready is flagged as a timeout, and the block parks in
// ERROR until software asks for a restart.
//
// Ports
//   clk            single clock, all logic on the rising edge
//   reset_n        asynchronous active-low reset (fabric reset)
//   pll_lock       raw PLL lock flag, asynchronous to clk
//   sw_rst_req     one-cycle restart request, synchronous to clk
//   stage_ready    per-stage ready levels, asynchronous to clk
//   stage_reset_n  per-stage active-low resets, registered
//   all_ready      every stage released and ready (RUN), registered
//   timeout_err    sticky timeout flag, registered
//   fail_stage     index of the stage that timed out, registered
//   dbg_state      current FSM state encoding, for observation only
//
// stage_ready is a level, not a handshake: a stage is considered up while
// its synchronized ready is high, and no acknowledge is returned.
// ---------------------------------------------------------------------------
module reset_release_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int DELAY_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LOCK_FILTER    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_lock,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  all_ready,
    output logic                  timeout_err,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] fail_stage,
    output logic [2:0]            dbg_state
);

    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int DW = $clog2(DELAY_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCK_FILTER + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RELEASE    = 3'd1,
        S_WAIT_READY = 3'd2,
        S_RUN        = 3'd3,
        S_ERROR      = 3'd4
    } state_t;

    state_t                state_q, state_d;

    logic                  lock_s1, lock_s2;
    logic [NUM_STAGES-1:0] rdy_s1, rdy_s2;
    logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
    logic                  lock_q;
    logic                  lock_ok;

    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         dly_q, dly_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [NUM_STAGES-1:0] srn_q, srn_d;
    logic                  ar_q, ar_d;
    logic                  te_q, te_d;
    logic [IW-1:0]         fs_q, fs_d;
    logic                  abort;

    // ------------------------------------------------------------------
    // Input synchronizers and lock qualification
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_s1    <= 1'b0;
            lock_s2    <= 1'b0;
            rdy_s1     <= '0;
            rdy_s2     <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_s1    <= pll_lock;
            lock_s2    <= lock_s1;
            rdy_s1     <= stage_ready;
            rdy_s2     <= rdy_s1;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_ok;
        end
    end

    // lock_ok is the value lock_q takes at the coming edge. The FSM acts on
    // it directly so that qualification and the first release share an
    // edge, and a lock drop aborts on the first edge the synced value is low.
    always_comb begin
        lock_ok    = lock_s2 && (lock_q || (lock_cnt_q == LW'(LOCK_FILTER - 1)));
        lock_cnt_d = lock_cnt_q;
        if (!lock_s2) begin
            lock_cnt_d = '0;
        end else if (!lock_ok) begin
            lock_cnt_d = lock_cnt_q + LW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: state and every output are registered here
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dly_q   <= '0;
            tmo_q   <= '0;
            srn_q   <= '0;
            ar_q    <= 1'b0;
            te_q    <= 1'b0;
            fs_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            tmo_q   <= tmo_d;
            srn_q   <= srn_d;
            ar_q    <= ar_d;
            te_q    <= te_d;
            fs_q    <= fs_d;
        end
    end

    // Software request outranks lock loss; both outrank timeout and advance.
    assign abort = ((state_q == S_RELEASE) || (state_q == S_WAIT_READY) || (state_q == S_RUN))
                   && (sw_rst_req || !lock_ok);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        tmo_d   = tmo_q;
        srn_d   = srn_q;
        ar_d    = ar_q;
        te_d    = te_q;
        fs_d    = fs_q;

        if (sw_rst_req) begin
            te_d = 1'b0;
            fs_d = '0;
        end

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            srn_d   = '0;
            ar_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    idx_d = '0;
                    srn_d = '0;
                    ar_d  = 1'b0;
                    if (lock_ok) begin
                        srn_d[0] = 1'b1;
                        dly_d    = '0;
                        state_d  = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (dly_q == DW'(DELAY_CYCLES - 1)) begin
                        tmo_d   = '0;
                        state_d = S_WAIT_READY;
                    end else begin
                        dly_d = dly_q + DW'(1);
                    end
                end
                S_WAIT_READY: begin
                    // The last counted cycle times out even if ready arrives with it.
                    if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        te_d    = 1'b1;
                        fs_d    = idx_q;
                        srn_d   = '0;
                        state_d = S_ERROR;
                    end else if (rdy_s2[idx_q]) begin
                        if (idx_q == IW'(NUM_STAGES - 1)) begin
                            ar_d    = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            idx_d        = idx_q + IW'(1);
                            srn_d[idx_d] = 1'b1;
                            dly_d        = '0;
                            state_d      = S_RELEASE;
                        end
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_RUN: begin
                    if (!(&rdy_s2)) begin
                        idx_d   = '0;
                        srn_d   = '0;
                        ar_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_ERROR: begin
                    srn_d = '0;
                    ar_d  = 1'b0;
                    if (sw_rst_req) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    idx_d   = '0;
                    srn_d   = '0;
                    ar_d    = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign stage_reset_n = srn_q;
    assign all_ready     = ar_q;
    assign timeout_err   = te_q;
    assign fail_stage    = fs_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_release_sequencer
//
// Output changes of the sequencer are predicted as (cycle, value) events by
// a schedule model: release edge r, ready seen at r+d+3, wait state entered
// at r+DLY, first possible advance at r+DLY+1, timeout at r+DLY+TMO.
// A negedge monitor pops one event per observed output change.
// ---------------------------------------------------------------------------
module tb_reset_release_sequencer;

    localparam int NS  = 4;
    localparam int DLY = 16;
    localparam int TMO = 1024;
    localparam int LF  = 8;

    logic          clk         = 1'b0;
    logic          reset_n     = 1'b1;
    logic          pll_lock    = 1'b0;
    logic          sw_rst_req  = 1'b0;
    logic [NS-1:0] stage_ready = '0;
    logic [NS-1:0] stage_reset_n;
    logic          all_ready;
    logic          timeout_err;
    logic [1:0]    fail_stage;
    logic [2:0]    dbg_state;

    reset_release_sequencer #(
        .NUM_STAGES    (NS),
        .DELAY_CYCLES  (DLY),
        .TIMEOUT_CYCLES(TMO),
        .LOCK_FILTER   (LF)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_lock     (pll_lock),
        .sw_rst_req   (sw_rst_req),
        .stage_ready  (stage_ready),
        .stage_reset_n(stage_reset_n),
        .all_ready    (all_ready),
        .timeout_err  (timeout_err),
        .fail_stage   (fail_stage),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [39:0] exp_q[$];          // {cycle[31:0], srn[3:0], all_ready, timeout_err, fail_stage[1:0]}
    int          rdy_at[NS];        // cycle after which stage_ready[k] is raised, -1 = never
    int          dly[NS];           // ready delay after release, -1 = never
    int          plan_r;
    int          plan_end;
    logic        mon_en   = 1'b0;
    logic [7:0]  prev_out = '0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [7:0]  cur;
        logic [39:0] e;
        cur = {stage_reset_n, all_ready, timeout_err, fail_stage};
        if (mon_en && (cur != prev_out)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_unexpected cyc=%0d got srn=%b ar=%b te=%b fs=%0d, required no change",
                         cyc, cur[7:4], cur[3], cur[2], cur[1:0]);
            end else begin
                e = exp_q.pop_front();
                if (e != {32'(cyc), cur}) begin
                    failures++;
                    $display("FAIL event cyc=%0d srn=%b ar=%b te=%b fs=%0d, required cyc=%0d srn=%b ar=%b te=%b fs=%0d",
                             cyc, cur[7:4], cur[3], cur[2], cur[1:0],
                             e[39:8], e[7:4], e[3], e[2], e[1:0]);
                end
            end
        end
        prev_out = cur;
    end

    // ---------------- driver tasks ----------------
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (rdy_at[k] == cyc) stage_ready[k] = 1'b1;
            end
        end
    endtask

    task automatic push_exp(input int c, input int srn, input logic ar, input logic te, input int fs);
        exp_q.push_back({32'(c), 4'(srn), ar, te, 2'(fs)});
    endtask

    task automatic clear_ready();
        stage_ready = '0;
        for (int k = 0; k < NS; k++) rdy_at[k] = -1;
    endtask

    task automatic rand_dly();
        for (int k = 0; k < NS; k++) dly[k] = int'($urandom_range(0, 30));
    endtask

    // Schedule model: stage 0 released at edge r0; stages before stop_k are
    // followed through to advance, timeout or RUN.
    task automatic plan(input int r0, input int stop_k);
        int r;
        int a;
        r = r0;
        for (int k = 0; k < NS; k++) rdy_at[k] = -1;
        push_exp(r0, 1, 1'b0, 1'b0, 0);
        plan_end = r0;
        for (int k = 0; k < NS; k++) begin
            if (k == stop_k) break;
            if (dly[k] >= 0) rdy_at[k] = r + dly[k];
            a = r + DLY + 1;
            if ((dly[k] >= 0) && (r + dly[k] + 3 > a)) a = r + dly[k] + 3;
            if ((dly[k] < 0) || (a >= r + DLY + TMO)) begin
                push_exp(r + DLY + TMO, 0, 1'b0, 1'b1, k);
                plan_end = r + DLY + TMO;
                break;
            end
            if (k == NS - 1) push_exp(a, (1 << NS) - 1, 1'b1, 1'b0, 0);
            else             push_exp(a, (1 << (k + 2)) - 1, 1'b0, 1'b0, 0);
            r        = a;
            plan_end = a;
        end
        plan_r = r;
    endtask

    task automatic check_out(input string name, input logic [7:0] req);
        logic [7:0] got;
        got = {stage_reset_n, all_ready, timeout_err, fail_stage};
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d got srn=%b ar=%b te=%b fs=%0d (state %0d), required srn=%b ar=%b te=%b fs=%0d",
                     name, cyc, got[7:4], got[3], got[2], got[1:0], dbg_state,
                     req[7:4], req[3], req[2], req[1:0]);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drained cyc=%0d got %0d pending events, required 0", name, cyc, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic sw_pulse();
        int s;
        s = cyc;
        push_exp(s + 1, 0, 1'b0, 1'b0, 0);
        sw_rst_req = 1'b1;
        step_to(s + 1);
        sw_rst_req = 1'b0;
        clear_ready();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got no end of run, required finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int e;
        int f;
        int r0;
        int kind;
        int kk;

        for (int k = 0; k < NS; k++) rdy_at[k] = -1;
        #1 reset_n = 1'b0;
        step_to(2);
        check_out("reset_state", 8'h00);
        mon_en = 1'b1;
        step_to(3);
        reset_n = 1'b1;

        // Lock glitch (5 high, 1 low), then nominal sequence with 5-cycle readies.
        step_to(10);
        pll_lock = 1'b1;
        step_to(15);
        pll_lock = 1'b0;
        step_to(16);
        pll_lock = 1'b1;
        for (int k = 0; k < NS; k++) dly[k] = 5;
        plan(16 + 2 + LF, NS);
        step_to(plan_end + 4);
        check_drained("nominal");
        check_out("nominal_run", 8'b1111_1_0_00);

        // Random aborts from RUN followed by full re-sequences.
        repeat (6) begin
            kind = int'($urandom_range(0, 2));
            e    = cyc + int'($urandom_range(1, 8));
            step_to(e);
            if (kind == 0) begin
                pll_lock = 1'b0;
                push_exp(e + 3, 0, 1'b0, 1'b0, 0);
                step_to(e + 3);
                clear_ready();
                f = e + 3 + int'($urandom_range(1, 6));
                step_to(f);
                pll_lock = 1'b1;
                r0 = f + 2 + LF;
            end else if (kind == 1) begin
                kk = int'($urandom_range(0, NS - 1));
                stage_ready[kk] = 1'b0;
                push_exp(e + 3, 0, 1'b0, 1'b0, 0);
                step_to(e + 3);
                clear_ready();
                r0 = e + 4;
            end else begin
                sw_pulse();
                r0 = e + 2;
            end
            rand_dly();
            plan(r0, NS);
            step_to(plan_end + int'($urandom_range(2, 6)));
            check_drained("abort_reseq");
            check_out("abort_reseq_run", 8'b1111_1_0_00);
        end

        // Ready of stage 1 and lock loss seen on the same edge: abort wins.
        e = cyc;
        sw_pulse();
        rand_dly();
        plan(e + 2, 1);
        e = plan_r + DLY + int'($urandom_range(0, 5));
        step_to(e);
        stage_ready[1] = 1'b1;
        pll_lock       = 1'b0;
        push_exp(e + 3, 0, 1'b0, 1'b0, 0);
        step_to(e + 40);
        check_drained("simultaneous");
        check_out("simultaneous_idle", 8'h00);

        // Stage 1 ready on the last allowed cycle, stage 2 never ready.
        clear_ready();
        f = cyc + 2;
        step_to(f);
        pll_lock = 1'b1;
        rand_dly();
        dly[1] = DLY + TMO - 4;
        dly[2] = -1;
        plan(f + 2 + LF, NS);
        step_to(plan_end + 20);
        check_drained("timeout");
        check_out("timeout_hold", 8'b0000_0_1_10);

        // Stage 3 ready seen on the timeout edge itself: timeout wins.
        e = cyc;
        sw_pulse();
        rand_dly();
        dly[3] = DLY + TMO - 3;
        plan(e + 2, NS);
        step_to(plan_end + 10);
        check_drained("timeout_tie");
        check_out("timeout_tie_hold", 8'b0000_0_1_11);

        // Asynchronous reset during RELEASE of stage 1.
        e = cyc;
        sw_pulse();
        rand_dly();
        plan(e + 2, 1);
        e = plan_r + int'($urandom_range(1, DLY - 2));
        step_to(e);
        push_exp(e, 0, 1'b0, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 8'h00);
        clear_ready();
        step_to(e + 3);
        reset_n = 1'b1;
        rand_dly();
        plan(e + 3 + 2 + LF, NS);
        step_to(plan_end + 4);
        check_drained("after_reset");
        check_out("after_reset_run", 8'b1111_1_0_00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
